// File: rtl/logic_gate_pipe.sv
// -----------------------------------------------------------------------------
// logic_gate_pipe
//   WIDTH-bit bitwise logic unit with eight run-time selectable operations,
//   followed by a DEPTH-stage elastic pipeline with valid/ready handshaking on
//   both sides and full backpressure.
//
//   op encoding: 0 NOT a, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 BUF a
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (ignored for NOT and BUF)
//   op         in   3      operation select, sampled on input transfer
//   in_valid   in   1      a/b/op valid this cycle
//   in_ready   out  1      unit accepts input this cycle
//   y          out  WIDTH  result (last pipeline stage)
//   out_valid  out  1      y holds a valid result
//   out_ready  in   1      consumer accepts y this cycle
// -----------------------------------------------------------------------------
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready
);

  // Bitwise operation selected by sel; BUF is the fall-through case.
  function automatic logic [WIDTH-1:0] gate_f(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = ~x;
      3'd1:    r = x & z;
      3'd2:    r = x | z;
      3'd3:    r = x ^ z;
      3'd4:    r = ~(x & z);
      3'd5:    r = ~(x | z);
      3'd6:    r = ~(x ^ z);
      default: r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]            f_s;
  logic [DEPTH-1:0]            adv_s;
  logic                        hole_s;
  logic [DEPTH:0]              up_v_s;
  logic [DEPTH:0][WIDTH-1:0]   up_d_s;

  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0]            v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_d;

  assign f_s = gate_f(op, a, b);

  // Stage k may advance when out_ready is high or any stage from k to the
  // last one holds a bubble; this is the adv chain unrolled from the output
  // side without a self-referencing vector.
  always_comb begin
    adv_s  = '0;
    hole_s = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hole_s   = hole_s | ~v_q[k];
      adv_s[k] = hole_s;
    end
  end

  // Upstream view of each stage: index 0 is the input port, k+1 is stage k.
  assign up_v_s = {v_q, in_valid};
  assign up_d_s = {d_q, f_s};

  // Next-state of every stage; data only loads when a valid item moves in.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (adv_s[k]) begin
        v_d[k] = up_v_s[k];
        if (up_v_s[k]) begin
          d_d[k] = up_d_s[k];
        end else begin
          d_d[k] = d_q[k];
        end
      end else begin
        v_d[k] = v_q[k];
        d_d[k] = d_q[k];
      end
    end
  end

  // Pipeline registers with synchronous reset clearing valids and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign in_ready  = adv_s[0];
  assign out_valid = v_q[DEPTH-1];
  assign y         = d_q[DEPTH-1];

endmodule

// File: tb/tb_logic_gate_pipe.sv
module tb_logic_gate_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  int               n_checks = 0;
  int               n_pass   = 0;
  int               acc_cnt  = 0;
  int               out_cnt  = 0;
  bit               model_on = 1'b0;
  bit               held     = 1'b0;
  logic [WIDTH-1:0] held_y;
  logic [WIDTH-1:0] exp_q[$];

  // Reference: per-bit truth tables indexed by {a_bit, b_bit}.
  function automatic logic [WIDTH-1:0] ref_f(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    logic [31:0]      tts;
    logic [3:0]       tt;
    logic [WIDTH-1:0] r;
    tts = {4'b1100, 4'b1001, 4'b0001, 4'b0111,
           4'b0110, 4'b1110, 4'b1000, 4'b0011};
    tt  = tts[o*4 +: 4];
    for (int i = 0; i < WIDTH; i++) r[i] = tt[{x[i], z[i]}];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: sample handshakes before the edge, update the model,
  // then check hold-stability after the edge.
  task automatic tick();
    bit in_f;
    bit out_f;
    #1;
    in_f  = in_valid & in_ready;
    out_f = out_valid & out_ready;
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else if (model_on) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (exp_q.size() < DEPTH) || out_ready});
      if (exp_q.size() == 0)     chk("empty_no_valid", {31'd0, out_valid}, 32'd0);
      if (exp_q.size() == DEPTH) chk("full_valid", {31'd0, out_valid}, 32'd1);
      if (out_f) begin
        if (exp_q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
        else begin
          chk("out_data", {24'd0, y}, {24'd0, exp_q.pop_front()});
          out_cnt++;
        end
      end
      if (in_f) begin
        exp_q.push_back(ref_f(op, a, b));
        acc_cnt++;
      end
      held   = out_valid & ~out_ready;
      held_y = y;
    end
    @(posedge clk);
    #1;
    if (held) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_y", {24'd0, y}, {24'd0, held_y});
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    chk("drain_empty", exp_q.size(), 32'd0);
    tick();
    chk("drain_idle", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    int   base_acc;
    int   base_out;
    for (int i = 0; i < 8; i++) begin
      tbl[i].op = 3'(i);
      tbl[i].a  = 8'hF0;
      tbl[i].b  = 8'hCC;
    end
    tbl[0].exp = 8'h0F; tbl[1].exp = 8'hC0; tbl[2].exp = 8'hFC; tbl[3].exp = 8'h3C;
    tbl[4].exp = 8'h3F; tbl[5].exp = 8'h03; tbl[6].exp = 8'hC3; tbl[7].exp = 8'hF0;

    // Reset held two cycles with input offered
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h00; op = 3'd0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_y", {24'd0, y}, 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0; model_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
    end

    // NOT latency: visible exactly DEPTH cycles later, for one cycle
    a = 8'hA5; op = 3'd0; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_y", {24'd0, y}, 32'h5A);
    tick();
    chk("lat_once", {31'd0, out_valid}, 32'd0);

    // All ops back-to-back, one result per cycle
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        op = tbl[i].op; a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        chk("ops_valid", {31'd0, out_valid}, 32'd1);
        chk("ops_y", {24'd0, y}, {24'd0, tbl[i-1].exp});
      end
    end
    drain();

    // Backpressure: 6 stalled cycles, 5 items offered
    base_acc = acc_cnt; base_out = out_cnt; out_ready = 1'b0; b = 8'h5C; op = 3'd3;
    for (int i = 0; i < 6; i++) begin
      a = 8'h10 + 8'(acc_cnt - base_acc); in_valid = 1'b1;
      tick();
    end
    chk("bp_accepted", acc_cnt - base_acc, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_y", {24'd0, y}, {24'd0, 8'h10 ^ 8'h5C});
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (acc_cnt - base_acc) < 5; k++) begin
      a = 8'h10 + 8'(acc_cnt - base_acc); in_valid = 1'b1;
      tick();
    end
    drain();
    chk("bp_emerged", out_cnt - base_out, 32'd5);

    // Bubble collapse: stalled head does not block an empty stage 0
    base_acc = acc_cnt; out_ready = 1'b0;
    a = 8'h3C; b = 8'h0F; op = 3'd1; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    a = 8'h81; op = 3'd2; in_valid = 1'b1;
    #1 chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk("bubble_two_held", acc_cnt - base_acc, 32'd2);
    drain();

    // Reset mid-flight discards in-flight items
    out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; op = 3'd0;
    tick(); a = 8'h22;
    tick(); in_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_y", {24'd0, y}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_gone", {31'd0, out_valid}, 32'd0);
    end
    a = 8'h96; b = 8'h0F; op = 3'd6; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("midrst_lat_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("midrst_lat_valid", {31'd0, out_valid}, 32'd1);
    chk("midrst_lat_y", {24'd0, y}, 32'h66);
    drain();

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = (i % 500 < 250) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
